adder_stim_gen: RTL

Synthesizable packet-stimulus source that sits directly upstream of the `adder` operand inputs in the characterization flow. It emits bursts of 2N-bit walking-ones/zeros flits, split into two N-bit operands, with a fixed inter-packet gap. It replaces the behavioural `send_data` task so that energy characterization runs can be driven from hardware at a controlled link utilization. A valid/ready handshake lets a registered consumer stall the stream without losing flits.

---
 rtl/adder_stim_gen_if.sv | 40 ++++
 rtl/adder_stim_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_stim_gen_if.sv
// adder_stim_gen_if
//
// Purpose: valid/ready flit channel between the adder stimulus generator
// and the operand inputs of the adder under characterization. One flit
// of 2N bits travels as two N-bit operands.
//
// Signals:
//   valid   producer -> consumer  input1/input2 hold a flit
//   ready   consumer -> producer  consumer accepts the current flit
//   input1  producer -> consumer  flit bits [N-1:0]
//   input2  producer -> consumer  flit bits [2N-1:N]
//
// Modports:
//   master  the stimulus generator (drives valid and operands)
//   slave   the consumer (drives ready)

interface adder_stim_gen_if #(
  parameter int N = 18
);

  logic         valid;
  logic         ready;
  logic [N-1:0] input1;
  logic [N-1:0] input2;

  modport master (
    output valid,
    output input1,
    output input2,
    input  ready
  );

  modport slave (
    input  valid,
    input  input1,
    input  input2,
    output ready
  );

endinterface

// File: rtl/adder_stim_gen.sv
// adder_stim_gen
//
// Purpose: hardware packet-stimulus source for the adder characterization
// flow. A run emits NUM_PKT packets of PAYLOAD flits each, separated by
// GAP idle cycles. Every flit is a 2N-bit walking-ones/zeros word, split
// into two N-bit operands. A valid/ready handshake lets a registered
// consumer stall the stream without losing or repeating flits.
//
// Parameters:
//   N        operand width, flit width W = 2N
//   PAYLOAD  flits per packet (>= 1)
//   GAP      idle cycles between packets (>= 0)
//   NUM_PKT  packets per run (>= 1)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   run request, only honoured while idle
//   bus       if   master side of the flit channel (valid/ready/input1/input2)
//   busy      out  a run is in progress
//   done      out  one-cycle pulse after the last flit of the run is accepted
//   pkt_cnt   out  packets completed in the current run
//   flit_cnt  out  flits accepted in the current packet
//
// Pattern: the flit is a function of an index m (0..W) and a phase p.
// L(m) has the low m bits set; the flit is L(m) when (m mod 2) xor p is
// zero, otherwise ~L(m). Each packet starts at m=1, p=0. The index then
// counts up; m=W at p=0 is followed by m=1 at p=1, and m=W-1 at p=1 is
// followed by m=0 at p=0, giving a period of 2W flits.

module adder_stim_gen #(
  parameter int N       = 18,
  parameter int PAYLOAD = 20,
  parameter int GAP     = 7,
  parameter int NUM_PKT = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  adder_stim_gen_if.master                   bus,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_PKT + 1) - 1:0]   pkt_cnt,
  output logic [$clog2(PAYLOAD + 1) - 1:0]   flit_cnt
);

  localparam int W  = 2 * N;
  localparam int MW = $clog2(W + 1);
  localparam int PW = $clog2(NUM_PKT + 1);
  localparam int FW = $clog2(PAYLOAD + 1);
  // The gap counter runs 0..GAP-1, so it needs at least one bit even
  // when the gap is zero or one cycle long.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [FW-1:0] FLIT_LAST = FW'(PAYLOAD - 1);
  localparam logic [PW-1:0] PKT_LAST  = PW'(NUM_PKT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [MW-1:0] M_FIRST   = MW'(1);
  localparam logic [MW-1:0] M_TOP     = MW'(W);
  localparam logic [MW-1:0] M_TOP_M1  = MW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  // Walking-ones/zeros word for index m and phase p.
  function automatic logic [W-1:0] patternFlit(input logic [MW-1:0] m,
                                                 input logic          p);
    logic [W-1:0] l;
    l = '0;
    for (int i = 0; i < W; i++) begin
      l[i] = (i < int'(m));
    end
    if ((m[0] ^ p) == 1'b0) begin
      return l;
    end else begin
      return ~l;
    end
  endfunction

  state_t          r_state;
  logic [MW-1:0]   r_m;
  logic            r_p;
  logic [W-1:0]    r_data;
  logic            r_valid;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_pkt_cnt;
  logic [FW-1:0]   r_flit_cnt;
  logic [GW-1:0]   r_gap_cnt;

  state_t          w_state_next;
  logic [MW-1:0]   w_m_next;
  logic            w_p_next;
  logic [W-1:0]    w_data_next;
  logic            w_valid_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic [PW-1:0]   w_pkt_cnt_next;
  logic [FW-1:0]   w_flit_cnt_next;
  logic [GW-1:0]   w_gap_cnt_next;

  logic [MW-1:0]   w_step_m;
  logic            w_step_p;
  logic [W-1:0]    w_step_flit;
  logic [W-1:0]    w_first_flit;

  // Successor of the pattern index currently on the bus. The two wrap
  // points are where the phase flips; everywhere else m simply counts up.
  always_comb begin
    w_step_m = r_m + MW'(1);
    w_step_p = r_p;
    if (!r_p && (r_m == M_TOP)) begin
      w_step_m = M_FIRST;
      w_step_p = 1'b1;
    end else if (r_p && (r_m == M_TOP_M1)) begin
      w_step_m = '0;
      w_step_p = 1'b0;
    end
    w_step_flit  = patternFlit(w_step_m, w_step_p);
    w_first_flit = patternFlit(M_FIRST, 1'b0);
  end

  // Next-state and next-output logic. Everything defaults to holding its
  // value, which is what keeps the operands frozen while the consumer
  // stalls and through the gap and idle periods; done is the only
  // self-clearing signal.
  always_comb begin
    w_state_next    = r_state;
    w_m_next        = r_m;
    w_p_next        = r_p;
    w_data_next     = r_data;
    w_valid_next    = r_valid;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    w_pkt_cnt_next  = r_pkt_cnt;
    w_flit_cnt_next = r_flit_cnt;
    w_gap_cnt_next  = r_gap_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next    = S_SEND;
          w_busy_next     = 1'b1;
          w_valid_next    = 1'b1;
          w_data_next     = w_first_flit;
          w_m_next        = M_FIRST;
          w_p_next        = 1'b0;
          w_pkt_cnt_next  = '0;
          w_flit_cnt_next = '0;
        end
      end

      S_SEND: begin
        if (r_valid && bus.ready) begin
          if (r_flit_cnt == FLIT_LAST) begin
            w_flit_cnt_next = '0;
            w_pkt_cnt_next  = r_pkt_cnt + PW'(1);
            if (r_pkt_cnt == PKT_LAST) begin
              w_state_next = S_IDLE;
              w_valid_next = 1'b0;
              w_busy_next  = 1'b0;
              w_done_next  = 1'b1;
            end else if (GAP == 0) begin
              // Back-to-back packets: the next packet's first flit
              // replaces the last one without a bubble.
              w_data_next = w_first_flit;
              w_m_next    = M_FIRST;
              w_p_next    = 1'b0;
            end else begin
              w_state_next   = S_GAP;
              w_valid_next   = 1'b0;
              w_gap_cnt_next = '0;
            end
          end else begin
            w_flit_cnt_next = r_flit_cnt + FW'(1);
            w_data_next     = w_step_flit;
            w_m_next        = w_step_m;
            w_p_next        = w_step_p;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_state_next = S_SEND;
          w_valid_next = 1'b1;
          w_data_next  = w_first_flit;
          w_m_next     = M_FIRST;
          w_p_next     = 1'b0;
        end else begin
          w_gap_cnt_next = r_gap_cnt + GW'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
        w_valid_next = 1'b0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State register. Reset clears the whole run immediately so that a
  // reset mid-packet never leaves a partial packet to resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_m        <= '0;
      r_p        <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pkt_cnt  <= '0;
      r_flit_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_m        <= w_m_next;
      r_p        <= w_p_next;
      r_data     <= w_data_next;
      r_valid    <= w_valid_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
      r_pkt_cnt  <= w_pkt_cnt_next;
      r_flit_cnt <= w_flit_cnt_next;
      r_gap_cnt  <= w_gap_cnt_next;
    end
  end

  // All outputs come straight from registers; ready only reaches them
  // through the next-state logic.
  assign bus.valid  = r_valid;
  assign bus.input1 = r_data[N-1:0];
  assign bus.input2 = r_data[W-1:N];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pkt_cnt    = r_pkt_cnt;
  assign flit_cnt   = r_flit_cnt;

endmodule
